position_anomaly_monitor: RTL

Multi-channel, parametrised GPS position jump detector. It compares each valid position sample against the previous one on every channel, in both directions. It raises a sticky alert only after a programmable number of consecutive anomalous samples, and reports which channels triggered it. It sits after the position solution stage and feeds the spoofing/integrity supervisor.

---
 rtl/position_anomaly_monitor_if.sv | 29 ++
 rtl/position_anomaly_monitor.sv | 137 +++++++++++++
 2 files changed

// File: rtl/position_anomaly_monitor_if.sv
// Bus between the position solution stage and the anomaly monitor.
// The master side supplies samples and configuration; the slave side
// (the monitor) returns the jump pulse, the sticky alert and its event count.
interface position_anomaly_monitor_if #(
    parameter int W     = 32,
    parameter int CH    = 2,
    parameter int CNT_W = 8,
    parameter int EVT_W = 8
);
    logic              pos_valid;
    logic [CH*W-1:0]   pos;
    logic [W-1:0]      thresh;
    logic [CNT_W-1:0]  persist;
    logic              clear;
    logic              alert;
    logic [CH-1:0]     alert_ch;
    logic              jump;
    logic [EVT_W-1:0]  evt_cnt;

    modport master (
        output pos_valid, pos, thresh, persist, clear,
        input  alert, alert_ch, jump, evt_cnt
    );

    modport slave (
        input  pos_valid, pos, thresh, persist, clear,
        output alert, alert_ch, jump, evt_cnt
    );
endinterface

// File: rtl/position_anomaly_monitor.sv
// Multi-channel GPS position jump detector. Each valid sample is compared
// against the previous one per channel (absolute step, no modular wrap).
// A sticky alert is raised after `persist` consecutive anomalous samples and
// records which channels were anomalous on the raising sample.
module position_anomaly_monitor #(
    parameter int W     = 32,
    parameter int CH    = 2,
    parameter int CNT_W = 8,
    parameter int EVT_W = 8
) (
    input  logic clk,
    input  logic rst,
    position_anomaly_monitor_if.slave bus
);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_TRACK = 2'd1,
        S_ALERT = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [CH*W-1:0]   last, last_nx;
    logic [CNT_W-1:0]  run, run_nx;
    logic              alert, alert_nx;
    logic [CH-1:0]     alert_ch, alert_ch_nx;
    logic              jump, jump_nx;
    logic [EVT_W-1:0]  evt_cnt, evt_cnt_nx;

    logic [CH-1:0]     anom;
    logic              any_anom;
    logic [CNT_W-1:0]  persist_eff;
    logic [CNT_W:0]    run_plus;
    logic              reach;
    logic [CNT_W-1:0]  run_sat;
    logic [EVT_W-1:0]  evt_sat;

    // Per-channel absolute step, computed one bit wider so 0 -> 2^W-1 is a
    // full-size step rather than a wrap of 1.
    for (genvar k = 0; k < CH; k++) begin : g_ch
        logic [W-1:0] cur;
        logic [W-1:0] prv;
        logic [W:0]   step;
        assign cur     = bus.pos[k*W +: W];
        assign prv     = last[k*W +: W];
        assign step    = (cur >= prv) ? ({1'b0, cur} - {1'b0, prv})
                                      : ({1'b0, prv} - {1'b0, cur});
        assign anom[k] = step > {1'b0, bus.thresh};
    end

    assign any_anom    = |anom;
    assign persist_eff = (bus.persist == '0) ? CNT_W'(1) : bus.persist;
    assign run_plus    = {1'b0, run} + (CNT_W+1)'(1);
    assign reach       = run_plus >= {1'b0, persist_eff};
    assign run_sat     = (run == '1) ? run : run + CNT_W'(1);
    assign evt_sat     = (evt_cnt == '1) ? evt_cnt : evt_cnt + EVT_W'(1);

    // Next-state and next-output decode; clear overrides any counting.
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        state_nx    = state;
        last_nx     = last;
        run_nx      = run;
        alert_nx    = alert;
        alert_ch_nx = alert_ch;
        jump_nx     = 1'b0;
        evt_cnt_nx  = evt_cnt;

        unique case (state)
            S_INIT: begin
                if (bus.pos_valid) begin
                    last_nx  = bus.pos;
                    state_nx = S_TRACK;
                end
            end
            S_TRACK, S_ALERT: begin
                if (bus.pos_valid) begin
                    last_nx = bus.pos;
                    jump_nx = any_anom;
                end
                if (bus.clear) begin
                    alert_nx    = 1'b0;
                    alert_ch_nx = '0;
                    run_nx      = '0;
                    state_nx    = S_TRACK;
                end else if (bus.pos_valid) begin
                    if (state == S_ALERT) begin
                        run_nx = '0;
                    end else if (!any_anom) begin
                        run_nx = '0;
                    end else if (reach) begin
                        state_nx    = S_ALERT;
                        alert_nx    = 1'b1;
                        alert_ch_nx = anom;
                        evt_cnt_nx  = evt_sat;
                        run_nx      = '0;
                    end else begin
                        run_nx = run_sat;
                    end
                end
            end
            default: state_nx = S_INIT;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking so every register sees pre-edge values.
        if (rst) state <= S_INIT;
        else     state <= state_nx;
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last     <= '0;
            run      <= '0;
            alert    <= 1'b0;
            alert_ch <= '0;
            jump     <= 1'b0;
            evt_cnt  <= '0;
        end else begin
            last     <= last_nx;
            run      <= run_nx;
            alert    <= alert_nx;
            alert_ch <= alert_ch_nx;
            jump     <= jump_nx;
            evt_cnt  <= evt_cnt_nx;
        end
    end

    assign bus.alert    = alert;
    assign bus.alert_ch = alert_ch;
    assign bus.jump     = jump;
    assign bus.evt_cnt  = evt_cnt;

endmodule
